// File: rtl/parking_pkg.sv
// Shared parking-gate definitions: state codes, default durations, timer helpers.
// Latency: none (declarations only).
// Backpressure: not applicable.
package parking_pkg;

  localparam int TIMER_W      = 12;
  localparam int DEF_CAPACITY = 8;
  localparam int DEF_ENTRY_MS = 2000;
  localparam int DEF_PAY_MS   = 2000;
  localparam int DEF_OPEN_MS  = 2000;

  // Encodings are visible on the state port and read by display/record blocks.
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ENTRY     = 3'd1,
    ST_EXIT_PAY  = 3'd2,
    ST_EXIT_OPEN = 3'd3
  } gate_state_e;

  // A state lasting dur cycles starts its down-counter at dur-1.
  function automatic logic [TIMER_W-1:0] load_value(input int dur);
    return TIMER_W'(dur - 1);
  endfunction

endpackage

// File: rtl/gate_timer.sv
// Loadable down-counter that times each gate session phase.
// Latency: count updates one cycle after load; zero is combinational from the count register.
// Backpressure: none; holds at zero until reloaded.
module gate_timer
  import parking_pkg::*;
(
  input  logic               ms,
  input  logic               rst_n,
  input  logic               load,
  input  logic [TIMER_W-1:0] value,
  output logic [TIMER_W-1:0] count,
  output logic               zero
);

  logic [TIMER_W-1:0] count_q;

  // Load takes priority; otherwise count down and stick at zero.
  always_ff @(posedge ms or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= value;
    end else if (count_q != '0) begin
      count_q <= count_q - 1'b1;
    end
  end

  assign count = count_q;
  assign zero  = (count_q == '0);

endmodule

// File: rtl/parking_gate_ctrl.sv
// Parking gate controller: lane arbitration, session FSM, occupancy count.
// Latency: request pulse pends on edge 1, grant/reject on edge 2; all outputs registered.
// Backpressure: requests pend while busy; refused requests are dropped with a reject strobe.
module parking_gate_ctrl
  import parking_pkg::*;
#(
  parameter int CAPACITY = DEF_CAPACITY,
  parameter int ENTRY_MS = DEF_ENTRY_MS,
  parameter int PAY_MS   = DEF_PAY_MS,
  parameter int OPEN_MS  = DEF_OPEN_MS
) (
  input  logic       ms,
  input  logic       rst_n,
  input  logic       entry_req,
  input  logic       exit_req,
  output logic [2:0] state,
  output logic       save_pulse,
  output logic       reject,
  output logic [3:0] occupied,
  output logic       full,
  output logic       empty
);

  localparam logic [TIMER_W-1:0] ENTRY_LOAD = load_value(ENTRY_MS);
  localparam logic [TIMER_W-1:0] PAY_LOAD   = load_value(PAY_MS);
  localparam logic [TIMER_W-1:0] OPEN_LOAD  = load_value(OPEN_MS);
  localparam logic [3:0]         CAP_OCC    = 4'(CAPACITY);

  gate_state_e        state_q, state_d;
  logic               pend_in_q, pend_in_d;
  logic               pend_out_q, pend_out_d;
  logic               last_exit_q, last_exit_d;
  logic [3:0]         occ_q, occ_d;
  logic               save_q, save_d;
  logic               reject_q, reject_d;
  logic               full_q, full_d;
  logic               empty_q, empty_d;

  logic               can_in, can_out;
  logic               take_in, take_out;
  logic               tmr_load;
  logic [TIMER_W-1:0] tmr_value;
  logic [TIMER_W-1:0] tmr_count;
  logic               tmr_zero;

  gate_timer u_timer (
    .ms    (ms),
    .rst_n (rst_n),
    .load  (tmr_load),
    .value (tmr_value),
    .count (tmr_count),
    .zero  (tmr_zero)
  );

  // Arbitration in IDLE, phase sequencing on timer expiry, pending-flag upkeep.
  always_comb begin
    state_d     = state_q;
    last_exit_d = last_exit_q;
    occ_d       = occ_q;
    save_d      = 1'b0;
    reject_d    = 1'b0;
    take_in     = 1'b0;
    take_out    = 1'b0;
    tmr_load    = 1'b0;
    tmr_value   = '0;
    can_in      = pend_in_q && !full_q;
    can_out     = pend_out_q && !empty_q;

    case (state_q)
      ST_IDLE: begin
        // Refusals are independent of the grant so both can happen on one edge.
        if (pend_in_q && full_q) begin
          take_in  = 1'b1;
          reject_d = 1'b1;
        end
        if (pend_out_q && empty_q) begin
          take_out = 1'b1;
          reject_d = 1'b1;
        end
        // The round-robin pointer only moves when both lanes actually compete.
        if (can_in && can_out) begin
          last_exit_d = !last_exit_q;
        end
        if (can_in && (!can_out || last_exit_q)) begin
          take_in   = 1'b1;
          state_d   = ST_ENTRY;
          tmr_load  = 1'b1;
          tmr_value = ENTRY_LOAD;
        end else if (can_out) begin
          take_out  = 1'b1;
          state_d   = ST_EXIT_PAY;
          tmr_load  = 1'b1;
          tmr_value = PAY_LOAD;
        end
      end
      ST_ENTRY: begin
        if (tmr_zero) begin
          state_d = ST_IDLE;
          occ_d   = occ_q + 4'd1;
          save_d  = 1'b1;
        end
      end
      ST_EXIT_PAY: begin
        if (tmr_zero) begin
          state_d   = ST_EXIT_OPEN;
          tmr_load  = 1'b1;
          tmr_value = OPEN_LOAD;
        end
      end
      ST_EXIT_OPEN: begin
        if (tmr_zero) begin
          state_d = ST_IDLE;
          occ_d   = occ_q - 4'd1;
          save_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A pulse landing while the flag is already set merges into it.
    pend_in_d  = take_in  ? 1'b0 : (pend_in_q  | entry_req);
    pend_out_d = take_out ? 1'b0 : (pend_out_q | exit_req);
    full_d     = (occ_d == CAP_OCC);
    empty_d    = (occ_d == 4'd0);
  end

  // State and output registers; reset aborts any session without a commit.
  always_ff @(posedge ms or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      pend_in_q   <= 1'b0;
      pend_out_q  <= 1'b0;
      last_exit_q <= 1'b1;
      occ_q       <= 4'd0;
      save_q      <= 1'b0;
      reject_q    <= 1'b0;
      full_q      <= 1'b0;
      empty_q     <= 1'b1;
    end else begin
      state_q     <= state_d;
      pend_in_q   <= pend_in_d;
      pend_out_q  <= pend_out_d;
      last_exit_q <= last_exit_d;
      occ_q       <= occ_d;
      save_q      <= save_d;
      reject_q    <= reject_d;
      full_q      <= full_d;
      empty_q     <= empty_d;
    end
  end

  // Sessions only return to IDLE once the timer has drained.
  idle_timer_drained: assert property (@(posedge ms) disable iff (!rst_n)
    (state_q == ST_IDLE) |-> (tmr_count == '0));

  assign state      = state_q;
  assign save_pulse = save_q;
  assign reject     = reject_q;
  assign occupied   = occ_q;
  assign full       = full_q;
  assign empty      = empty_q;

endmodule

// File: tb/tb_parking_gate_ctrl.sv
// Bench for parking_gate_ctrl: directed session scenarios plus randomized reference-model run.
// Latency: n/a.
// Backpressure: n/a.
module tb_parking_gate_ctrl;

  logic ms = 1'b0;
  always #5 ms = ~ms;

  // Instance A: default parameters.
  logic       a_rst_n, a_entry, a_exit;
  logic [2:0] a_state;
  logic       a_save, a_rej, a_full, a_empty;
  logic [3:0] a_occ;

  parking_gate_ctrl dut_a (
    .ms(ms), .rst_n(a_rst_n), .entry_req(a_entry), .exit_req(a_exit),
    .state(a_state), .save_pulse(a_save), .reject(a_rej),
    .occupied(a_occ), .full(a_full), .empty(a_empty)
  );

  // Instance B: short timings, small capacity.
  localparam int B_CAP = 3, B_ENTRY = 1, B_PAY = 3, B_OPEN = 2;
  logic       b_rst_n, b_entry, b_exit;
  logic [2:0] b_state;
  logic       b_save, b_rej, b_full, b_empty;
  logic [3:0] b_occ;

  parking_gate_ctrl #(.CAPACITY(B_CAP), .ENTRY_MS(B_ENTRY), .PAY_MS(B_PAY), .OPEN_MS(B_OPEN)) dut_b (
    .ms(ms), .rst_n(b_rst_n), .entry_req(b_entry), .exit_req(b_exit),
    .state(b_state), .save_pulse(b_save), .reject(b_rej),
    .occupied(b_occ), .full(b_full), .empty(b_empty)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state for instance B.
  int m_state, m_remain, m_occ;
  bit m_pin, m_pout, m_last_exit, m_save, m_rej;

  task automatic pulse_a(input bit e, input bit x);
    @(negedge ms);
    a_entry = e;
    a_exit  = x;
    @(negedge ms);
    a_entry = 1'b0;
    a_exit  = 1'b0;
  endtask

  task automatic wait_a(input logic [2:0] s, input int limit, output bit ok);
    int k;
    k = 0;
    while (a_state !== s && k < limit) begin
      @(negedge ms);
      k++;
    end
    ok = (a_state === s);
  endtask

  task automatic run_a(input logic [2:0] s, input int limit, output int n);
    n = 0;
    while (a_state === s && n < limit) begin
      @(negedge ms);
      n++;
    end
  endtask

  task automatic do_entry_a(output bit ok);
    bit ok1;
    int n;
    pulse_a(1'b1, 1'b0);
    wait_a(3'd1, 10, ok1);
    run_a(3'd1, 3000, n);
    ok = ok1 && (n == 2000) && (a_state === 3'd0) && (a_save === 1'b1);
  endtask

  task automatic model_reset();
    m_state = 0; m_remain = 0; m_occ = 0;
    m_pin = 0; m_pout = 0; m_last_exit = 1; m_save = 0; m_rej = 0;
  endtask

  task automatic model_step(input bit ein, input bit xin);
    bit g_in, g_out, r_in, r_out;
    g_in = 0; g_out = 0; r_in = 0; r_out = 0;
    m_save = 0;
    m_rej  = 0;
    case (m_state)
      0: begin
        r_in  = m_pin && (m_occ == B_CAP);
        r_out = m_pout && (m_occ == 0);
        if (m_pin && !r_in && m_pout && !r_out) begin
          if (m_last_exit) g_in = 1; else g_out = 1;
          m_last_exit = g_out;
        end else begin
          g_in  = m_pin && !r_in;
          g_out = m_pout && !r_out;
        end
        m_rej = r_in || r_out;
        if (g_in) begin m_state = 1; m_remain = B_ENTRY; end
        else if (g_out) begin m_state = 2; m_remain = B_PAY; end
      end
      1: if (m_remain == 1) begin m_state = 0; m_occ++; m_save = 1; end else m_remain--;
      2: if (m_remain == 1) begin m_state = 3; m_remain = B_OPEN; end else m_remain--;
      3: if (m_remain == 1) begin m_state = 0; m_occ--; m_save = 1; end else m_remain--;
      default: m_state = 0;
    endcase
    m_pin  = (g_in || r_in)   ? 1'b0 : (m_pin | ein);
    m_pout = (g_out || r_out) ? 1'b0 : (m_pout | xin);
  endtask

  task automatic test_reset();
    a_entry = 0; a_exit = 0; b_entry = 0; b_exit = 0;
    a_rst_n = 1; b_rst_n = 1;
    #1;
    a_rst_n = 0; b_rst_n = 0;
    repeat (3) @(negedge ms);
    n_checks++;
    if ({a_state, a_occ, a_save, a_rej, a_full, a_empty} !== {3'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL reset_a: got st=%0d occ=%0d sv=%b rj=%b fl=%b em=%b, want 0 0 0 0 0 1",
               a_state, a_occ, a_save, a_rej, a_full, a_empty);
    end
    n_checks++;
    if ({b_state, b_occ, b_save, b_rej, b_full, b_empty} !== {3'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL reset_b: got st=%0d occ=%0d sv=%b rj=%b fl=%b em=%b, want 0 0 0 0 0 1",
               b_state, b_occ, b_save, b_rej, b_full, b_empty);
    end
    a_rst_n = 1; b_rst_n = 1;
  endtask

  task automatic test_single_entry();
    int n;
    pulse_a(1'b1, 1'b0);
    n_checks++;
    if (a_state !== 3'd0) begin n_fail++; $display("FAIL s1_pending_idle: state=%0d want 0", a_state); end
    @(negedge ms);
    n_checks++;
    if (a_state !== 3'd1) begin n_fail++; $display("FAIL s1_grant: state=%0d want 1", a_state); end
    run_a(3'd1, 5000, n);
    n_checks++;
    if (n != 2000) begin n_fail++; $display("FAIL s1_entry_len: got %0d want 2000", n); end
    n_checks++;
    if ({a_state, a_save, a_occ, a_empty} !== {3'd0, 1'b1, 4'd1, 1'b0}) begin
      n_fail++;
      $display("FAIL s1_commit: st=%0d sv=%b occ=%0d em=%b want 0 1 1 0", a_state, a_save, a_occ, a_empty);
    end
    @(negedge ms);
    n_checks++;
    if (a_save !== 1'b0) begin n_fail++; $display("FAIL s1_save_width: save=%b want 0", a_save); end
  endtask

  task automatic test_single_exit();
    int n1, n2;
    pulse_a(1'b0, 1'b1);
    @(negedge ms);
    n_checks++;
    if (a_state !== 3'd2) begin n_fail++; $display("FAIL s2_grant: state=%0d want 2", a_state); end
    run_a(3'd2, 5000, n1);
    n_checks++;
    if (n1 != 2000 || a_state !== 3'd3) begin
      n_fail++; $display("FAIL s2_pay_len: got %0d then st=%0d want 2000 then 3", n1, a_state);
    end
    run_a(3'd3, 5000, n2);
    n_checks++;
    if (n2 != 2000) begin n_fail++; $display("FAIL s2_open_len: got %0d want 2000", n2); end
    n_checks++;
    if ({a_state, a_save, a_occ, a_empty} !== {3'd0, 1'b1, 4'd0, 1'b1}) begin
      n_fail++;
      $display("FAIL s2_commit: st=%0d sv=%b occ=%0d em=%b want 0 1 0 1", a_state, a_save, a_occ, a_empty);
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    int n;
    for (int i = 0; i < 3; i++) begin
      do_entry_a(ok);
      n_checks++;
      if (!ok || a_occ !== 4'(i + 1)) begin
        n_fail++; $display("FAIL s3_fill%0d: ok=%b occ=%0d want 1 %0d", i, ok, a_occ, i + 1);
      end
    end
    // First conflict: entry wins, exit follows right after the commit cycle.
    pulse_a(1'b1, 1'b1);
    @(negedge ms);
    n_checks++;
    if (a_state !== 3'd1) begin n_fail++; $display("FAIL s3_first_conflict: state=%0d want 1", a_state); end
    run_a(3'd1, 5000, n);
    n_checks++;
    if (n != 2000 || {a_state, a_save, a_occ} !== {3'd0, 1'b1, 4'd4}) begin
      n_fail++; $display("FAIL s3_entry_done: n=%0d st=%0d sv=%b occ=%0d want 2000 0 1 4", n, a_state, a_save, a_occ);
    end
    @(negedge ms);
    n_checks++;
    if (a_state !== 3'd2) begin n_fail++; $display("FAIL s3_exit_b2b: state=%0d want 2", a_state); end
    run_a(3'd2, 5000, n);
    run_a(3'd3, 5000, n);
    n_checks++;
    if ({a_state, a_save, a_occ} !== {3'd0, 1'b1, 4'd3}) begin
      n_fail++; $display("FAIL s3_exit_done: st=%0d sv=%b occ=%0d want 0 1 3", a_state, a_save, a_occ);
    end
    // Second conflict: exit wins this time.
    pulse_a(1'b1, 1'b1);
    @(negedge ms);
    n_checks++;
    if (a_state !== 3'd2) begin n_fail++; $display("FAIL s3_second_conflict: state=%0d want 2", a_state); end
    run_a(3'd2, 5000, n);
    run_a(3'd3, 5000, n);
    @(negedge ms);
    n_checks++;
    if (a_state !== 3'd1 || a_occ !== 4'd2) begin
      n_fail++; $display("FAIL s3_entry_b2b: st=%0d occ=%0d want 1 2", a_state, a_occ);
    end
    run_a(3'd1, 5000, n);
    n_checks++;
    if (a_occ !== 4'd3) begin n_fail++; $display("FAIL s3_final_occ: occ=%0d want 3", a_occ); end
  endtask

  task automatic test_reset_mid_session();
    bit ok;
    int n;
    bit saw_save;
    for (int i = 0; i < 2; i++) begin
      do_entry_a(ok);
      n_checks++;
      if (!ok) begin n_fail++; $display("FAIL s5_fill%0d: entry session incomplete, occ=%0d", i, a_occ); end
    end
    n_checks++;
    if (a_occ !== 4'd5) begin n_fail++; $display("FAIL s5_occ5: occ=%0d want 5", a_occ); end
    pulse_a(1'b0, 1'b1);
    wait_a(3'd2, 10, ok);
    repeat (999) @(negedge ms);
    n_checks++;
    if (!ok || a_state !== 3'd2) begin n_fail++; $display("FAIL s5_in_pay: state=%0d want 2", a_state); end
    #1 a_rst_n = 1'b0;
    #1;
    n_checks++;
    if ({a_state, a_occ, a_save, a_rej, a_full, a_empty} !== {3'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL s5_async_reset: st=%0d occ=%0d sv=%b rj=%b fl=%b em=%b want 0 0 0 0 0 1",
               a_state, a_occ, a_save, a_rej, a_full, a_empty);
    end
    saw_save = 0;
    repeat (3) begin @(negedge ms); saw_save |= a_save; end
    a_rst_n = 1'b1;
    repeat (5) begin @(negedge ms); saw_save |= a_save; end
    n_checks++;
    if (saw_save || a_state !== 3'd0 || a_occ !== 4'd0) begin
      n_fail++; $display("FAIL s5_no_commit: save_seen=%b st=%0d occ=%0d want 0 0 0", saw_save, a_state, a_occ);
    end
    // Exit at empty is refused.
    pulse_a(1'b0, 1'b1);
    @(negedge ms);
    n_checks++;
    if ({a_rej, a_state} !== {1'b1, 3'd0}) begin
      n_fail++; $display("FAIL s4_empty_reject: rj=%b st=%0d want 1 0", a_rej, a_state);
    end
    @(negedge ms);
    n_checks++;
    if (a_rej !== 1'b0) begin n_fail++; $display("FAIL s4_reject_width: rj=%b want 0", a_rej); end
    // Both pending at empty: exit refused and entry granted on the same edge.
    pulse_a(1'b1, 1'b1);
    @(negedge ms);
    n_checks++;
    if ({a_rej, a_state} !== {1'b1, 3'd1}) begin
      n_fail++; $display("FAIL s19_same_edge: rj=%b st=%0d want 1 1", a_rej, a_state);
    end
    repeat (10) @(negedge ms);
    pulse_a(1'b1, 1'b0);
    run_a(3'd1, 5000, n);
    n_checks++;
    if ({a_state, a_save, a_occ} !== {3'd0, 1'b1, 4'd1}) begin
      n_fail++; $display("FAIL s5_first_done: st=%0d sv=%b occ=%0d want 0 1 1", a_state, a_save, a_occ);
    end
    @(negedge ms);
    n_checks++;
    if (a_state !== 3'd1) begin n_fail++; $display("FAIL s5_queued_entry: state=%0d want 1", a_state); end
    run_a(3'd1, 5000, n);
    n_checks++;
    if (n != 2000 || a_occ !== 4'd2) begin
      n_fail++; $display("FAIL s5_queued_done: n=%0d occ=%0d want 2000 2", n, a_occ);
    end
  endtask

  task automatic test_full_reject();
    bit ok;
    for (int i = 0; i < 6; i++) begin
      do_entry_a(ok);
      n_checks++;
      if (!ok || a_occ !== 4'(i + 3)) begin
        n_fail++; $display("FAIL s4_fill%0d: ok=%b occ=%0d want 1 %0d", i, ok, a_occ, i + 3);
      end
    end
    @(negedge ms);
    n_checks++;
    if ({a_full, a_empty, a_occ} !== {1'b1, 1'b0, 4'd8}) begin
      n_fail++; $display("FAIL s4_full: fl=%b em=%b occ=%0d want 1 0 8", a_full, a_empty, a_occ);
    end
    pulse_a(1'b1, 1'b0);
    @(negedge ms);
    n_checks++;
    if ({a_rej, a_state, a_full, a_occ} !== {1'b1, 3'd0, 1'b1, 4'd8}) begin
      n_fail++; $display("FAIL s4_full_reject: rj=%b st=%0d fl=%b occ=%0d want 1 0 1 8", a_rej, a_state, a_full, a_occ);
    end
    @(negedge ms);
    n_checks++;
    if ({a_rej, a_state} !== {1'b0, 3'd0}) begin
      n_fail++; $display("FAIL s4_after_reject: rj=%b st=%0d want 0 0", a_rej, a_state);
    end
  endtask

  task automatic test_short_entry();
    @(negedge ms);
    b_entry = 1'b1;
    @(negedge ms);
    b_entry = 1'b0;
    @(negedge ms);
    n_checks++;
    if (b_state !== 3'd1) begin n_fail++; $display("FAIL s6_grant: state=%0d want 1", b_state); end
    @(negedge ms);
    n_checks++;
    if ({b_state, b_save, b_occ} !== {3'd0, 1'b1, 4'd1}) begin
      n_fail++; $display("FAIL s6_one_cycle: st=%0d sv=%b occ=%0d want 0 1 1", b_state, b_save, b_occ);
    end
  endtask

  task automatic test_random();
    int errs;
    errs = 0;
    @(negedge ms);
    b_entry = 0; b_exit = 0;
    b_rst_n = 0;
    model_reset();
    @(negedge ms);
    b_rst_n = 1;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      b_entry = ($urandom_range(0, 3) == 0);
      b_exit  = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 299) == 0) begin
        b_entry = 0; b_exit = 0;
        b_rst_n = 0;
        model_reset();
        @(negedge ms);
        b_rst_n = 1;
      end else begin
        @(posedge ms);
        model_step(b_entry, b_exit);
        @(negedge ms);
      end
      n_checks++;
      if ({b_state, b_occ, b_save, b_rej, b_full, b_empty} !==
          {3'(m_state), 4'(m_occ), m_save, m_rej, (m_occ == B_CAP), (m_occ == 0)}) begin
        n_fail++;
        errs++;
        if (errs <= 10)
          $display("FAIL rand_cyc%0d: got st=%0d occ=%0d sv=%b rj=%b fl=%b em=%b want st=%0d occ=%0d sv=%b rj=%b",
                   cyc, b_state, b_occ, b_save, b_rej, b_full, b_empty, m_state, m_occ, m_save, m_rej);
      end
    end
    b_entry = 0; b_exit = 0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single_entry();
    test_single_exit();
    test_back_to_back();
    test_reset_mid_session();
    test_full_reject();
    test_short_entry();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
